z80_daisy_irq: RTL and testbench

- Z80 Mode-2 daisy-chain interrupt controller for a multi-channel peripheral such as the CTC, with up to NCH internal sources.
- Sits directly downstream of the RETI/acknowledge detector. It consumes that detector's SPM1 (M1 & IORQ acknowledge) and RETI pulse.
- Drives INT_n, IEO and the acknowledge vector onto the CPU data bus.
- Tracks per-channel pending and in-service state, with internal fixed priority: channel 0 is highest.

---
 rtl/z80_irq_pkg.sv | 23 ++
 rtl/z80_daisy_chan.sv | 29 ++
 rtl/z80_daisy_irq.sv | 88 ++++++++
 tb/tb_z80_daisy_irq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/z80_irq_pkg.sv
// Shared constants and helpers for the Z80 mode-2 daisy-chain interrupt controller.
package z80_irq_pkg;
  localparam int NCH_MAX = 8;

  // Returns {found, index} of the lowest set bit; index 0 is highest priority.
  function automatic logic [3:0] prio_lowest(input logic [NCH_MAX-1:0] vec);
    logic [3:0] r;
    r = '0;
    for (int i = NCH_MAX - 1; i >= 0; i--)
      if (vec[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  // Replaces bits [chw:1] of the vector base with the channel index.
  function automatic logic [7:0] vec_insert(input logic [7:0] base, input logic [2:0] idx,
                                            input int chw);
    logic [7:0] r;
    r = base;
    for (int i = 0; i < 3; i++)
      if (i < chw) r[i+1] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/z80_daisy_chan.sv
// One interrupt channel: pending / in-service flops and their set/clear ordering.
module z80_daisy_chan
  import z80_irq_pkg::*;
(
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic I_CLKEN,
  input  logic irq,
  input  logic ie,
  input  logic ack,
  input  logic reti_clr,
  output logic pend,
  output logic insv
);
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      pend <= 1'b0;
      insv <= 1'b0;
    end else if (I_CLKEN) begin
      // A fresh request beats the acknowledge clear so it is not lost.
      if (!ie)      pend <= 1'b0;
      else if (irq) pend <= 1'b1;
      else if (ack) pend <= 1'b0;
      // RETI clear is based on the old state; ack set lands on top of it.
      if (ack)           insv <= 1'b1;
      else if (reti_clr) insv <= 1'b0;
    end
  end
endmodule

// File: rtl/z80_daisy_irq.sv
// Z80 mode-2 daisy-chain interrupt controller: priority, acknowledge vector, RETI, IEI/IEO.
module z80_daisy_irq
  import z80_irq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           I_CLK,
  input  logic           I_RESET,
  input  logic           I_CLKEN,
  input  logic [NCH-1:0] I_IRQ,
  input  logic [NCH-1:0] I_IE,
  input  logic [7:0]     I_VEC_BASE,
  input  logic           I_IEI,
  input  logic           I_SPM1,
  input  logic           I_RETI,
  output logic           O_INT_n,
  output logic           O_IEO,
  output logic [7:0]     O_VEC,
  output logic           O_VEC_OE,
  output logic [NCH-1:0] O_ACK
);
  logic [NCH-1:0]     pend, insv, blk, elig, ack_vec, reti_vec;
  logic [NCH_MAX-1:0] elig8, insv8;
  logic [3:0]         ack_sel, reti_sel;
  logic               spm1_r, ack_valid, ack_fire, reti_fire;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      blk[k] = 1'b0;
      for (int j = 0; j <= k; j++) blk[k] = blk[k] | insv[j];
    end
    elig  = pend & ~blk & {NCH{I_IEI}};
    elig8 = '0;
    insv8 = '0;
    elig8[NCH-1:0] = elig;
    insv8[NCH-1:0] = insv;
  end

  assign ack_sel   = prio_lowest(elig8);
  assign reti_sel  = prio_lowest(insv8);
  assign ack_fire  = I_CLKEN & I_SPM1 & ~spm1_r & I_IEI & ack_sel[3];
  assign reti_fire = I_CLKEN & I_RETI & I_IEI & reti_sel[3];

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ack_vec[k]  = ack_fire  && (ack_sel[2:0]  == 3'(k));
      reti_vec[k] = reti_fire && (reti_sel[2:0] == 3'(k));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    z80_daisy_chan u_chan (
      .I_CLK    (I_CLK),
      .I_RESET  (I_RESET),
      .I_CLKEN  (I_CLKEN),
      .irq      (I_IRQ[k] & I_IE[k]),
      .ie       (I_IE[k]),
      .ack      (ack_vec[k]),
      .reti_clr (reti_vec[k]),
      .pend     (pend[k]),
      .insv     (insv[k])
    );
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      spm1_r    <= 1'b0;
      ack_valid <= 1'b0;
      O_VEC     <= 8'h00;
      O_ACK     <= '0;
    end else if (I_CLKEN) begin
      spm1_r <= I_SPM1;
      O_ACK  <= ack_vec;
      if (ack_fire) begin
        ack_valid <= 1'b1;
        O_VEC     <= vec_insert(I_VEC_BASE, ack_sel[2:0], CHW);
      end else if (!I_SPM1) begin
        ack_valid <= 1'b0;
      end
    end
  end

  assign O_INT_n  = ~(|elig & ~ack_valid);
  assign O_VEC_OE = I_SPM1 & ack_valid & ~I_RESET;
  // Pending requests only hold off downstream during the acknowledge cycle itself.
  assign O_IEO    = I_IEI & ~(|insv) & ~(I_SPM1 & |pend);
endmodule

// File: tb/tb_z80_daisy_irq.sv
// Directed self-checking bench for z80_daisy_irq (NCH=4, CHW=2).
module tb_z80_daisy_irq;
  logic       I_CLK = 1'b0;
  logic       I_RESET = 1'b1;
  logic       I_CLKEN = 1'b1;
  logic [3:0] I_IRQ = '0;
  logic [3:0] I_IE = 4'hF;
  logic [7:0] I_VEC_BASE = 8'h40;
  logic       I_IEI = 1'b1;
  logic       I_SPM1 = 1'b0;
  logic       I_RETI = 1'b0;
  logic       O_INT_n, O_IEO, O_VEC_OE;
  logic [7:0] O_VEC;
  logic [3:0] O_ACK;
  int total = 0;
  int bad = 0;

  z80_daisy_irq #(.NCH(4), .CHW(2)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_CLKEN(I_CLKEN), .I_IRQ(I_IRQ), .I_IE(I_IE),
    .I_VEC_BASE(I_VEC_BASE), .I_IEI(I_IEI), .I_SPM1(I_SPM1), .I_RETI(I_RETI),
    .O_INT_n(O_INT_n), .O_IEO(O_IEO), .O_VEC(O_VEC), .O_VEC_OE(O_VEC_OE), .O_ACK(O_ACK)
  );

  always #5 I_CLK = ~I_CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic pulse_irq(input logic [3:0] m);
    I_IRQ = m; tick(); I_IRQ = '0;
  endtask

  task automatic release_spm1();
    I_SPM1 = 1'b0; tick();
  endtask

  task automatic pulse_reti();
    I_RETI = 1'b1; tick(); I_RETI = 1'b0;
  endtask

  task automatic test_reset();
    I_RESET = 1'b1; tick(); tick(); I_RESET = 1'b0; tick();
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL rst_int got=%b exp=1", O_INT_n); end
    total++; if (O_VEC_OE !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", O_VEC_OE); end
    total++; if (O_VEC !== 8'h00) begin bad++; $display("FAIL rst_vec got=%h exp=00", O_VEC); end
    total++; if (O_ACK !== 4'h0) begin bad++; $display("FAIL rst_ack got=%b exp=0000", O_ACK); end
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL rst_ieo got=%b exp=1", O_IEO); end
    I_IEI = 1'b0; #1;
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL rst_ieo_follow got=%b exp=0", O_IEO); end
    I_IEI = 1'b1; #1;
  endtask

  task automatic test_clken();
    I_CLKEN = 1'b0; pulse_irq(4'b0001); I_CLKEN = 1'b1; tick();
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL clken_hold got=%b exp=1", O_INT_n); end
  endtask

  task automatic test_single();
    pulse_irq(4'b0100);
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL single_int got=%b exp=0", O_INT_n); end
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL single_ieo_pend got=%b exp=1", O_IEO); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC !== 8'h44) begin bad++; $display("FAIL single_vec got=%h exp=44", O_VEC); end
    total++; if (O_VEC_OE !== 1'b1) begin bad++; $display("FAIL single_oe got=%b exp=1", O_VEC_OE); end
    total++; if (O_ACK !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", O_ACK); end
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL single_int_ack got=%b exp=1", O_INT_n); end
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL single_ieo_insv got=%b exp=0", O_IEO); end
    release_spm1();
    total++; if (O_VEC_OE !== 1'b0) begin bad++; $display("FAIL single_oe_off got=%b exp=0", O_VEC_OE); end
    total++; if (O_ACK !== 4'b0000) begin bad++; $display("FAIL single_ack_pulse got=%b exp=0000", O_ACK); end
    pulse_reti();
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL single_reti_ieo got=%b exp=1", O_IEO); end
  endtask

  task automatic test_priority();
    pulse_irq(4'b1010);
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC !== 8'h42) begin bad++; $display("FAIL prio_vec1 got=%h exp=42", O_VEC); end
    total++; if (O_ACK !== 4'b0010) begin bad++; $display("FAIL prio_ack1 got=%b exp=0010", O_ACK); end
    release_spm1();
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL prio_ieo got=%b exp=0", O_IEO); end
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL prio_int_blk got=%b exp=1", O_INT_n); end
    pulse_reti();
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL prio_int_ch3 got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC !== 8'h46) begin bad++; $display("FAIL prio_vec3 got=%h exp=46", O_VEC); end
    total++; if (O_ACK !== 4'b1000) begin bad++; $display("FAIL prio_ack3 got=%b exp=1000", O_ACK); end
    release_spm1(); pulse_reti();
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL prio_done_ieo got=%b exp=1", O_IEO); end
  endtask

  task automatic test_nesting();
    pulse_irq(4'b1000);
    I_SPM1 = 1'b1; tick(); release_spm1();
    pulse_irq(4'b0001);
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL nest_int got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC !== 8'h40) begin bad++; $display("FAIL nest_vec got=%h exp=40", O_VEC); end
    total++; if (O_ACK !== 4'b0001) begin bad++; $display("FAIL nest_ack got=%b exp=0001", O_ACK); end
    release_spm1(); pulse_reti();
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL nest_reti1_ieo got=%b exp=0", O_IEO); end
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL nest_reti1_int got=%b exp=1", O_INT_n); end
    pulse_reti();
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL nest_reti2_ieo got=%b exp=1", O_IEO); end
  endtask

  task automatic test_iei_low();
    pulse_irq(4'b1000);
    I_SPM1 = 1'b1; tick(); release_spm1();
    I_IEI = 1'b0;
    pulse_irq(4'b0010);
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL iei_int got=%b exp=1", O_INT_n); end
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL iei_ieo got=%b exp=0", O_IEO); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_ACK !== 4'b0000) begin bad++; $display("FAIL iei_noack got=%b exp=0000", O_ACK); end
    total++; if (O_VEC_OE !== 1'b0) begin bad++; $display("FAIL iei_oe got=%b exp=0", O_VEC_OE); end
    release_spm1(); pulse_reti();
    I_IEI = 1'b1; #1;
    // ch3 must still be in service; ch1 outranks it so it may interrupt.
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL iei_reti_ign got=%b exp=0", O_IEO); end
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL iei_restore_int got=%b exp=0", O_INT_n); end
    pulse_reti();
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL iei_reti3_ieo got=%b exp=1", O_IEO); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC !== 8'h42) begin bad++; $display("FAIL iei_vec1 got=%h exp=42", O_VEC); end
    release_spm1(); pulse_reti();
  endtask

  task automatic test_reti_ack_same();
    pulse_irq(4'b1000);
    I_SPM1 = 1'b1; tick(); release_spm1();
    pulse_irq(4'b0001);
    I_SPM1 = 1'b1; I_RETI = 1'b1; tick(); I_RETI = 1'b0;
    total++; if (O_ACK !== 4'b0001) begin bad++; $display("FAIL same_ack got=%b exp=0001", O_ACK); end
    release_spm1();
    total++; if (O_IEO !== 1'b0) begin bad++; $display("FAIL same_ieo got=%b exp=0", O_IEO); end
    pulse_reti();
    total++; if (O_IEO !== 1'b1) begin bad++; $display("FAIL same_ieo_clr got=%b exp=1", O_IEO); end
  endtask

  task automatic test_back_to_back();
    pulse_irq(4'b0100);
    I_SPM1 = 1'b1; I_IRQ = 4'b0100; tick(); I_IRQ = '0;
    total++; if (O_ACK !== 4'b0100) begin bad++; $display("FAIL b2b_ack got=%b exp=0100", O_ACK); end
    total++; if (O_VEC !== 8'h44) begin bad++; $display("FAIL b2b_vec got=%h exp=44", O_VEC); end
    release_spm1();
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL b2b_int_blk got=%b exp=1", O_INT_n); end
    pulse_reti();
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL b2b_repend got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1; tick();
    total++; if (O_ACK !== 4'b0100) begin bad++; $display("FAIL b2b_ack2 got=%b exp=0100", O_ACK); end
    release_spm1(); pulse_reti();
  endtask

  task automatic test_ie_and_reset();
    pulse_irq(4'b0010);
    total++; if (O_INT_n !== 1'b0) begin bad++; $display("FAIL ie_pend got=%b exp=0", O_INT_n); end
    I_IE = 4'b1101; tick();
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL ie_clear got=%b exp=1", O_INT_n); end
    I_IE = 4'hF; tick();
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL ie_stays got=%b exp=1", O_INT_n); end
    pulse_irq(4'b0001);
    I_SPM1 = 1'b1; tick();
    total++; if (O_VEC_OE !== 1'b1) begin bad++; $display("FAIL rstack_oe got=%b exp=1", O_VEC_OE); end
    I_RESET = 1'b1; #1;
    total++; if (O_VEC_OE !== 1'b0) begin bad++; $display("FAIL rstack_oe_now got=%b exp=0", O_VEC_OE); end
    tick();
    total++; if (O_VEC !== 8'h00) begin bad++; $display("FAIL rstack_vec got=%h exp=00", O_VEC); end
    total++; if (O_ACK !== 4'b0000) begin bad++; $display("FAIL rstack_ack got=%b exp=0000", O_ACK); end
    I_RESET = 1'b0; tick();
    total++; if (O_ACK !== 4'b0000) begin bad++; $display("FAIL rstack_noack got=%b exp=0000", O_ACK); end
    total++; if (O_VEC_OE !== 1'b0) begin bad++; $display("FAIL rstack_oe_after got=%b exp=0", O_VEC_OE); end
    total++; if (O_INT_n !== 1'b1) begin bad++; $display("FAIL rstack_int got=%b exp=1", O_INT_n); end
    release_spm1();
  endtask

  initial begin
    test_reset();
    test_clken();
    test_single();
    test_priority();
    test_nesting();
    test_iei_low();
    test_reti_ack_same();
    test_back_to_back();
    test_ie_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
